uart_frame_tx: RTL and testbench

//  Serialises pre-framed 10-bit UART words (start, 8 data, stop) from the keyboard scanner onto one TX line.

---
 rtl/piano_uart_pkg.sv | 19 +
 rtl/baud_tick_gen.sv | 29 ++
 rtl/uart_frame_tx.sv | 133 +++++++++++++
 tb/tb_uart_frame_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_uart_pkg.sv
// Shared UART framing types and helpers for the piano keyboard link (TX side now, RX later).
package piano_uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   FRAME_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Wraps a data byte into a line frame; bit 0 is the first bit on the wire.
  function automatic logic [FRAME_W-1:0] mk_frame(input logic [7:0] d);
    return {STOP_BIT, d, START_BIT};
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-cell timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // Holding the count at zero while disabled aligns the first cell to the enabling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Serialises pre-framed UART words (start, data, stop) LSB first onto tx, then holds an idle gap.
// Handshake: a frame transfers on a rising edge where ivalid and iready are both high; iready
// is a registered output, ivalid with iready low is ignored and nothing is buffered.
module uart_frame_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FRAME_W      = 10,
  parameter int GAP_BITS     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] inputData,
  input  logic               ivalid,
  output logic               iready,
  output logic               tx,
  output logic               tx_done,
  output logic               frame_err,
  output logic [1:0]         dbg_state
);

  import piano_uart_pkg::*;

  localparam int IDX_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_BITS - 1);

  tx_state_t          state, state_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
  logic [GAP_W-1:0]   gap_idx, gap_idx_nxt;
  logic               tx_nxt, iready_nxt, done_nxt, err_nxt;
  logic               tick, frame_ok;

  assign dbg_state = state;
  assign frame_ok  = (inputData[0] == START_BIT) && (inputData[FRAME_W-1] == STOP_BIT);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      gap_idx   <= '0;
      tx        <= 1'b1;
      iready    <= 1'b1;
      tx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_idx   <= bit_idx_nxt;
      gap_idx   <= gap_idx_nxt;
      tx        <= tx_nxt;
      iready    <= iready_nxt;
      tx_done   <= done_nxt;
      frame_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    gap_idx_nxt = gap_idx;
    tx_nxt      = tx;
    iready_nxt  = iready;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt     = 1'b1;
        iready_nxt = 1'b1;
        if (ivalid && iready) begin
          if (frame_ok) begin
            state_nxt   = SHIFT;
            shreg_nxt   = inputData;
            bit_idx_nxt = '0;
            tx_nxt      = inputData[0];
            iready_nxt  = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_idx == LAST_IDX) begin
            tx_nxt      = 1'b1;
            bit_idx_nxt = IDX_W'(FRAME_W);
            gap_idx_nxt = '0;
            if (GAP_BITS == 0) begin
              state_nxt  = IDLE;
              iready_nxt = 1'b1;
              done_nxt   = 1'b1;
            end else begin
              state_nxt = GAP;
            end
          end else begin
            shreg_nxt   = shreg >> 1;
            tx_nxt      = shreg[1];
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      GAP: begin
        tx_nxt = 1'b1;
        if (tick) begin
          if (gap_idx == LAST_GAP) begin
            state_nxt  = IDLE;
            iready_nxt = 1'b1;
            done_nxt   = 1'b1;
          end else begin
            gap_idx_nxt = gap_idx + GAP_W'(1);
          end
        end
      end
      default: begin
        state_nxt  = IDLE;
        tx_nxt     = 1'b1;
        iready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx at 4 clocks per bit and one gap cell; a line monitor decodes every frame.
module tb_uart_frame_tx;

  localparam int CPB    = 4;
  localparam int FW     = 10;
  localparam int PERIOD = (FW + 1) * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [FW-1:0] inputData = '0;
  logic          ivalid = 1'b0;
  logic          iready, tx, tx_done, frame_err;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .FRAME_W(FW), .GAP_BITS(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .inputData(inputData),
    .ivalid   (ivalid),
    .iready   (iready),
    .tx       (tx),
    .tx_done  (tx_done),
    .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Line monitor: samples the middle of each cell and checks the frame against the queue.
  logic [FW-1:0] mon_bits;
  logic [FW-1:0] mon_exp;
  bit            mon_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        mon_abort = 1'b0;
        mon_bits  = '0;
        for (int c = 1; c <= 2 + (FW - 1) * CPB; c++) begin
          if (c > 1) @(negedge clk);
          if (reset_n !== 1'b1) mon_abort = 1'b1;
          if (c >= 2 && ((c - 2) % CPB) == 0) mon_bits[(c - 2) / CPB] = tx;
        end
        if (!mon_abort) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor_unexpected: got frame %h required none", mon_bits);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_bits !== mon_exp) begin
              errors++;
              $display("FAIL monitor_frame: got %h required %h", mon_bits, mon_exp);
            end
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ({tx, iready, tx_done, frame_err} !== 4'b1100 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d tx/iready/done/err=%b state=%0d required 1100 state 0",
                 k, {tx, iready, tx_done, frame_err}, dbg_state);
      end
    end
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    logic exp_tx;
    f = piano_uart_pkg::mk_frame(8'h31);
    checks++;
    if (f !== 10'h262) begin
      errors++;
      $display("FAIL mk_frame: got %h required 262", f);
    end
    inputData = 10'h262;
    ivalid    = 1'b1;
    exp_q.push_back(10'h262);
    @(posedge clk);
    for (int k = 0; k <= PERIOD + 1; k++) begin
      @(negedge clk);
      if (k == 0) ivalid = 1'b0;
      exp_tx = (k < FW * CPB) ? f[k / CPB] : 1'b1;
      checks++;
      if (tx !== exp_tx || iready !== (k >= PERIOD) || tx_done !== (k == PERIOD) || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL single_frame: cycle %0d tx=%b iready=%b done=%b err=%b required tx=%b iready=%b done=%b err=0",
                 k, tx, iready, tx_done, frame_err, exp_tx, k >= PERIOD, k == PERIOD);
      end
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: pending %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_malformed();
    logic [FW-1:0] bad [3];
    bad[0] = 10'h000;
    bad[1] = 10'h3FF;
    bad[2] = 10'h0FE;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      inputData = bad[p];
      ivalid    = 1'b1;
      @(negedge clk);
      ivalid = 1'b0;
      checks++;
      if (frame_err !== 1'b1 || tx !== 1'b1 || iready !== 1'b1) begin
        errors++;
        $display("FAIL malformed_pulse: word %h err=%b tx=%b iready=%b required 1 1 1",
                 bad[p], frame_err, tx, iready);
      end
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b0 || tx !== 1'b1 || iready !== 1'b1 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL malformed_after: word %h err=%b tx=%b iready=%b state=%0d required 0 1 1 0",
                 bad[p], frame_err, tx, iready, dbg_state);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f;
    logic exp_tx;
    int p;
    f = 10'h262;
    @(negedge clk);
    inputData = f;
    ivalid    = 1'b1;
    repeat (3) exp_q.push_back(f);
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 95) ivalid = 1'b0;
      p = k % (PERIOD + 1);
      exp_tx = (p < FW * CPB) ? f[p / CPB] : 1'b1;
      checks++;
      if (tx !== exp_tx || iready !== (p == PERIOD) || tx_done !== (p == PERIOD)) begin
        errors++;
        $display("FAIL back_to_back: cycle %0d tx=%b iready=%b done=%b required tx=%b iready=%b done=%b",
                 k, tx, iready, tx_done, exp_tx, p == PERIOD, p == PERIOD);
      end
    end
    for (int i = 0; i < 200 && (exp_q.size() != 0 || iready !== 1'b1); i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || iready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: pending %0d iready=%b required 0 pending iready 1", exp_q.size(), iready);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    inputData = 10'h262;
    ivalid    = 1'b1;
    exp_q.push_back(10'h262);
    @(posedge clk);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 0) ivalid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (tx !== 1'b1 || iready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: tx=%b iready=%b state=%0d required 1 1 0", tx, iready, dbg_state);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    inputData = 10'h2AA;
    ivalid    = 1'b1;
    exp_q.push_back(10'h2AA);
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) ivalid = 1'b0;
      if (iready === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != PERIOD) begin
      errors++;
      $display("FAIL reset_resume_latency: got %0d required %0d", lat, PERIOD);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_resume_drain: pending %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_noise();
    logic [FW-1:0] f;
    logic exp_tx;
    f = 10'h2C6;
    @(negedge clk);
    inputData = f;
    ivalid    = 1'b1;
    exp_q.push_back(f);
    @(posedge clk);
    for (int k = 0; k <= PERIOD; k++) begin
      @(negedge clk);
      if (k < 38) begin
        ivalid    = 1'($urandom_range(0, 1));
        inputData = (k % 3 == 0) ? piano_uart_pkg::mk_frame(8'($urandom)) : FW'($urandom);
      end else begin
        ivalid = 1'b0;
      end
      exp_tx = (k < FW * CPB) ? f[k / CPB] : 1'b1;
      checks++;
      if (tx !== exp_tx || frame_err !== 1'b0 || iready !== (k == PERIOD)) begin
        errors++;
        $display("FAIL noise_ignored: cycle %0d tx=%b err=%b iready=%b required tx=%b err=0 iready=%b",
                 k, tx, frame_err, iready, exp_tx, k == PERIOD);
      end
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL noise_drain: pending %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_malformed();
    test_back_to_back();
    test_reset_mid();
    test_noise();
    repeat (60) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
